// File: rtl/uart_baud_gen_frac_if.sv
// Control/status bundle between the UART register block (master) and the baud
// tick generator (slave).
interface uart_baud_gen_frac_if #(
   parameter int CNT_W  = 16,
   parameter int FRAC_W = 4,
   parameter int OVS    = 16
);
   localparam int OVS_W = $clog2(OVS);

   logic              enable;
   logic              resync;
   logic              cfg_load;
   logic [CNT_W-1:0]  baud_val;
   logic [FRAC_W-1:0] baud_frac;
   logic              baud_clock;
   logic              xmit_pulse;
   logic [OVS_W-1:0]  tick_cnt;
   logic              cfg_pending;

   modport master (
      output enable, resync, cfg_load, baud_val, baud_frac,
      input  baud_clock, xmit_pulse, tick_cnt, cfg_pending
   );

   modport slave (
      input  enable, resync, cfg_load, baud_val, baud_frac,
      output baud_clock, xmit_pulse, tick_cnt, cfg_pending
   );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// OVS-x baud tick generator with shadowed divisor applied on bit boundaries.
// Define UART_BAUD_FRAC_EN to build the fractional accumulator; otherwise baud_frac is ignored.
module uart_baud_gen_frac #(
   parameter int CNT_W      = 16,
   parameter int FRAC_W     = 4,
   parameter int OVS        = 16,
   parameter int RESET_BAUD = 0
) (
   input  logic                clk,
   input  logic                reset,
   uart_baud_gen_frac_if.slave bus
);
   localparam int               OVS_W     = $clog2(OVS);
   localparam logic [OVS_W-1:0] LAST_TICK = OVS_W'(OVS - 1);
   localparam logic [CNT_W-1:0] RESET_VAL = CNT_W'(RESET_BAUD);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OVS_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             baud_clock_q, baud_clock_d;
   logic             xmit_pulse_q, xmit_pulse_d;
   logic [CNT_W-1:0] active_val_q, active_val_d;
   logic [CNT_W-1:0] shadow_val_q, shadow_val_d;
   logic             cfg_pending_q, cfg_pending_d;

   logic stretch_now;
   logic cnt_zero;
   logic tick_fire;
   logic bit_end;
   logic apply_cfg;

   assign cnt_zero  = (cnt_q == '0);
   assign tick_fire = !bus.resync && bus.enable && cnt_zero && !stretch_now;
   assign bit_end   = tick_fire && (tick_cnt_q == LAST_TICK);
   // A new divisor may only land where it cannot split a bit in flight.
   assign apply_cfg = cfg_pending_q && (bit_end || bus.resync || !bus.enable);

   always_comb begin
      cnt_d        = cnt_q;
      tick_cnt_d   = tick_cnt_q;
      baud_clock_d = 1'b0;
      xmit_pulse_d = 1'b0;
      if (bus.resync) begin
         cnt_d      = active_val_q;
         tick_cnt_d = '0;
      end else if (bus.enable) begin
         if (tick_fire) begin
            baud_clock_d = 1'b1;
            xmit_pulse_d = bit_end;
            cnt_d        = active_val_q;
            tick_cnt_d   = tick_cnt_q + OVS_W'(1);
         end else if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // The running count is never reloaded here; active_val is picked up at the next reload.
   always_comb begin
      active_val_d  = apply_cfg ? shadow_val_q : active_val_q;
      shadow_val_d  = bus.cfg_load ? bus.baud_val : shadow_val_q;
      cfg_pending_d = bus.cfg_load || (cfg_pending_q && !apply_cfg);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= '0;
         tick_cnt_q    <= '0;
         baud_clock_q  <= 1'b0;
         xmit_pulse_q  <= 1'b0;
         active_val_q  <= RESET_VAL;
         shadow_val_q  <= RESET_VAL;
         cfg_pending_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         tick_cnt_q    <= tick_cnt_d;
         baud_clock_q  <= baud_clock_d;
         xmit_pulse_q  <= xmit_pulse_d;
         active_val_q  <= active_val_d;
         shadow_val_q  <= shadow_val_d;
         cfg_pending_q <= cfg_pending_d;
      end
   end

`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [FRAC_W-1:0] active_frac_q, active_frac_d;
   logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
   logic              stretch_q, stretch_d;
   logic [FRAC_W:0]   acc_sum;

   assign stretch_now = stretch_q;
   assign acc_sum     = {1'b0, acc_q} + {1'b0, active_frac_q};

   // A carry out of the phase accumulator inserts one extra idle cycle before the next tick.
   always_comb begin
      acc_d     = acc_q;
      stretch_d = stretch_q;
      if (bus.resync) begin
         acc_d     = '0;
         stretch_d = 1'b0;
      end else if (bus.enable && cnt_zero) begin
         if (stretch_q) begin
            stretch_d = 1'b0;
         end else begin
            acc_d     = acc_sum[FRAC_W-1:0];
            stretch_d = acc_sum[FRAC_W];
         end
      end
   end

   always_comb begin
      active_frac_d = apply_cfg ? shadow_frac_q : active_frac_q;
      shadow_frac_d = bus.cfg_load ? bus.baud_frac : shadow_frac_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q         <= '0;
         stretch_q     <= 1'b0;
         active_frac_q <= '0;
         shadow_frac_q <= '0;
      end else begin
         acc_q         <= acc_d;
         stretch_q     <= stretch_d;
         active_frac_q <= active_frac_d;
         shadow_frac_q <= shadow_frac_d;
      end
   end
`else
   logic unused_baud_frac;

   assign stretch_now      = 1'b0;
   assign unused_baud_frac = ^bus.baud_frac;
`endif

   assign bus.baud_clock  = baud_clock_q;
   assign bus.xmit_pulse  = xmit_pulse_q;
   assign bus.tick_cnt    = tick_cnt_q;
   assign bus.cfg_pending = cfg_pending_q;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: hand-derived vector table, directed corner sequences,
// and randomized traffic checked against a tick-schedule reference model.
module tb_uart_baud_gen_frac;
   localparam int CNT_W      = 8;
   localparam int FRAC_W     = 4;
   localparam int OVS        = 16;
   localparam int RESET_BAUD = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_baud_gen_frac_if #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS)) bus ();

   uart_baud_gen_frac #(
      .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS), .RESET_BAUD(RESET_BAUD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_assert++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: actual %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: counts cycles remaining until the next tick, with the
   // fractional remainder kept as a plain integer sum modulo 2^FRAC_W.
   int m_wait, m_frac_sum, m_bit, m_aval, m_afrac, m_sval, m_sfrac;
   bit m_pend, m_bc, m_xp;

   task automatic model_step(input bit rst, input bit en, input bit rs, input bit ld,
                             input int val, input int frac);
      bit apply_now;
      if (rst) begin
         m_wait = 0; m_frac_sum = 0; m_bit = 0; m_aval = RESET_BAUD; m_afrac = 0;
         m_pend = 0; m_bc = 0; m_xp = 0;
         return;
      end
      m_bc = 0;
      m_xp = 0;
      if (rs) begin
         m_wait = m_aval; m_frac_sum = 0; m_bit = 0;
      end else if (en) begin
         if (m_wait == 0) begin
            m_bc  = 1;
            m_xp  = (m_bit == OVS - 1);
            m_bit = (m_bit + 1) % OVS;
`ifdef UART_BAUD_FRAC_EN
            begin
               int total;
               total      = m_frac_sum + m_afrac;
               m_frac_sum = total % (1 << FRAC_W);
               m_wait     = m_aval + total / (1 << FRAC_W);
            end
`else
            m_wait = m_aval;
`endif
         end else begin
            m_wait--;
         end
      end
      apply_now = m_pend && (m_xp || rs || !en);
      if (apply_now) begin m_aval = m_sval; m_afrac = m_sfrac; end
      if (ld) begin m_sval = val; m_sfrac = frac; m_pend = 1; end
      else if (apply_now) m_pend = 0;
   endtask

   task automatic drive(input bit en, input bit rs, input bit ld, input int val, input int frac);
      bus.enable    = en;
      bus.resync    = rs;
      bus.cfg_load  = ld;
      bus.baud_val  = CNT_W'(val);
      bus.baud_frac = FRAC_W'(frac);
   endtask

   task automatic step(input bit cmp);
      model_step(reset, bus.enable, bus.resync, bus.cfg_load, int'(bus.baud_val), int'(bus.baud_frac));
      @(posedge clk);
      #1;
      if (cmp) begin
         check("rand_baud_clock", bus.baud_clock, m_bc);
         check("rand_xmit_pulse", bus.xmit_pulse, m_xp);
         check("rand_tick_cnt", bus.tick_cnt, m_bit);
         check("rand_cfg_pending", bus.cfg_pending, m_pend);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1, 0, 0, 0, 0);
      step(0);
      step(0);
      reset = 1'b0;
   endtask

   task automatic cfg(input int val, input int frac);
      drive(1, 0, 1, val, frac);
      step(0);
      drive(1, 0, 0, 0, 0);
   endtask

   task automatic resync_pulse();
      drive(1, 1, 0, 0, 0);
      step(0);
      drive(1, 0, 0, 0, 0);
   endtask

   int q_tick[$];
   int q_xp[$];
   int q_xp_ord[$];
   int stray;

   task automatic measure(input int ncyc);
      int ord = 0;
      q_tick.delete(); q_xp.delete(); q_xp_ord.delete(); stray = 0;
      for (int c = 0; c < ncyc; c++) begin
         step(0);
         if (bus.baud_clock) begin ord++; q_tick.push_back(c); end
         if (bus.xmit_pulse) begin
            q_xp.push_back(c); q_xp_ord.push_back(ord);
            if (!bus.baud_clock) stray++;
         end
      end
   endtask

   function automatic int tick_at(input int i);
      return (i < q_tick.size()) ? q_tick[i] : -1000;
   endfunction
   function automatic int xp_at(input int i);
      return (i < q_xp.size()) ? q_xp[i] : -1000;
   endfunction
   function automatic int bad_intervals(input int period);
      int bad = 0;
      for (int i = 1; i < q_tick.size(); i++)
         if (q_tick[i] - q_tick[i-1] != period) bad++;
      return bad;
   endfunction

   typedef struct {
      bit rst; bit en; bit rs; bit ld; int val;
      bit bc;  bit xp; int tc; bit pend;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input bit rst, input bit en, input bit rs, input bit ld, input int val,
                      input bit bc, input bit xp, input int tc, input bit pend);
      vec_t v;
      v.rst = rst; v.en = en; v.rs = rs; v.ld = ld; v.val = val;
      v.bc = bc; v.xp = xp; v.tc = tc; v.pend = pend;
      vecs.push_back(v);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int found, bad, held;
      reset = 1'b1;
      drive(1, 0, 0, 0, 0);

      // Vector table from reset (RESET_BAUD=2 -> period 3): tick, resync, enable hold, cfg apply.
      add(1,1,0,0,0, 0,0,0,0);
      add(1,1,0,0,0, 0,0,0,0);
      add(0,1,0,0,0, 1,0,1,0);
      add(0,1,0,0,0, 0,0,1,0);
      add(0,1,0,0,0, 0,0,1,0);
      add(0,1,0,0,0, 1,0,2,0);
      add(0,1,0,0,0, 0,0,2,0);
      add(0,1,0,0,0, 0,0,2,0);
      add(0,1,0,0,0, 1,0,3,0);
      add(0,1,1,0,0, 0,0,0,0);
      add(0,1,0,0,0, 0,0,0,0);
      add(0,1,0,0,0, 0,0,0,0);
      add(0,1,0,0,0, 1,0,1,0);
      add(0,0,0,0,0, 0,0,1,0);
      add(0,0,0,0,0, 0,0,1,0);
      add(0,1,0,0,0, 0,0,1,0);
      add(0,1,0,0,0, 0,0,1,0);
      add(0,1,0,0,0, 1,0,2,0);
      add(0,1,0,1,5, 0,0,2,1);
      add(0,0,0,0,0, 0,0,2,0);
      add(0,1,0,0,0, 0,0,2,0);
      add(0,1,0,0,0, 1,0,3,0);
      for (int i = 0; i < 5; i++) add(0,1,0,0,0, 0,0,3,0);
      add(0,1,0,0,0, 1,0,4,0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst;
         drive(vecs[i].en, vecs[i].rs, vecs[i].ld, vecs[i].val, 0);
         step(0);
         $display("vec %0d: rst=%0b en=%0b rs=%0b ld=%0b -> bc=%0b xp=%0b tc=%0d pend=%0b",
                  i, vecs[i].rst, vecs[i].en, vecs[i].rs, vecs[i].ld,
                  bus.baud_clock, bus.xmit_pulse, bus.tick_cnt, bus.cfg_pending);
         check($sformatf("vec%0d_baud_clock", i), bus.baud_clock, vecs[i].bc);
         check($sformatf("vec%0d_xmit_pulse", i), bus.xmit_pulse, vecs[i].xp);
         check($sformatf("vec%0d_tick_cnt", i), bus.tick_cnt, vecs[i].tc);
         check($sformatf("vec%0d_cfg_pending", i), bus.cfg_pending, vecs[i].pend);
      end
      reset = 1'b0;
      drive(1, 0, 0, 0, 0);

      // A: divisor 3 -> tick every 4 cycles, xmit every 64 on the 16th tick.
      do_reset(); cfg(3, 0); resync_pulse();
      check("a_pending_after_resync", bus.cfg_pending, 0);
      measure(200);
      $display("seq A: %0d ticks, %0d xmit pulses", q_tick.size(), q_xp.size());
      check("a_tick_count", q_tick.size(), 50);
      check("a_bad_periods", bad_intervals(4), 0);
      check("a_first_xmit_tick_ord", (q_xp_ord.size() > 0) ? q_xp_ord[0] : -1, 16);
      check("a_xmit_period", xp_at(1) - xp_at(0), 64);
      check("a_stray_xmit", stray, 0);

      // B: divisor 0 -> baud_clock constantly high; enable low freezes.
      do_reset(); cfg(0, 0); resync_pulse();
      measure(64);
      $display("seq B: %0d ticks, first xmit at %0d", q_tick.size(), xp_at(0));
      check("b_tick_count", q_tick.size(), 62);
      check("b_first_tick", tick_at(0), 2);
      check("b_xmit_period", xp_at(1) - xp_at(0), 16);
      held = int'(bus.tick_cnt);
      bad = 0;
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0);
         if (bus.baud_clock || bus.xmit_pulse || int'(bus.tick_cnt) != held) bad++;
      end
      check("b_disabled_cycles_bad", bad, 0);
      drive(1, 0, 0, 0, 0);
      step(0);
      check("b_resume_tick", bus.baud_clock, 1);
      check("b_resume_tick_cnt", bus.tick_cnt, (held + 1) % OVS);

      // C: fractional divisor 3 + 8/16.
      do_reset(); cfg(3, 8); resync_pulse();
      measure(120);
      $display("seq C: ticks at %0d %0d %0d, tick16 at %0d", tick_at(0), tick_at(1), tick_at(2), tick_at(16));
`ifdef UART_BAUD_FRAC_EN
      check("c_first_period", tick_at(1) - tick_at(0), 4);
      check("c_second_period", tick_at(2) - tick_at(1), 5);
      check("c_span_16_ticks", tick_at(16) - tick_at(0), 72);
`else
      check("c_first_period", tick_at(1) - tick_at(0), 4);
      check("c_second_period", tick_at(2) - tick_at(1), 4);
      check("c_span_16_ticks", tick_at(16) - tick_at(0), 64);
`endif

      // D: reconfigure 3 -> 7 mid-bit; pending until the xmit tick.
      do_reset(); cfg(3, 0); resync_pulse();
      found = 0;
      for (int c = 0; c < 400 && found == 0; c++) begin
         step(0);
         if (bus.baud_clock && bus.tick_cnt == 5) found = 1;
      end
      check("d_reach_tick5", found, 1);
      cfg(7, 0);
      check("d_pending_set", bus.cfg_pending, 1);
      found = 0; bad = 0;
      for (int c = 0; c < 400 && found == 0; c++) begin
         step(0);
         if (bus.xmit_pulse) found = 1;
         else if (!bus.cfg_pending) bad++;
      end
      check("d_xmit_seen", found, 1);
      check("d_pending_dropped_early", bad, 0);
      check("d_pending_clear_at_xmit", bus.cfg_pending, 0);
      measure(40);
      $display("seq D: ticks after apply at %0d %0d %0d", tick_at(0), tick_at(1), tick_at(2));
      check("d_old_period_finishes", tick_at(0), 3);
      check("d_new_period_1", tick_at(1) - tick_at(0), 8);
      check("d_new_period_2", tick_at(2) - tick_at(1), 8);

      // E: resync with cnt=2, tick_cnt=9 under divisor 7.
      found = 0;
      for (int c = 0; c < 400 && found == 0; c++) begin
         step(0);
         if (bus.baud_clock && bus.tick_cnt == 9) found = 1;
      end
      check("e_reach_tick9", found, 1);
      for (int i = 0; i < 5; i++) step(0);
      resync_pulse();
      check("e_tick_cnt_cleared", bus.tick_cnt, 0);
      check("e_no_tick_on_resync", bus.baud_clock, 0);
      measure(20);
      $display("seq E: ticks after resync at %0d %0d", tick_at(0), tick_at(1));
      check("e_first_tick_after_resync", tick_at(0), 7);
      check("e_second_tick", tick_at(1), 15);
      check("e_no_xmit", q_xp.size(), 0);

      // F: reset with config pending discards it; period back to RESET_BAUD+1.
      cfg(5, 0);
      check("f_pending_before_reset", bus.cfg_pending, 1);
      reset = 1'b1;
      step(0);
      check("f_reset_baud_clock", bus.baud_clock, 0);
      check("f_reset_xmit", bus.xmit_pulse, 0);
      check("f_reset_tick_cnt", bus.tick_cnt, 0);
      check("f_reset_pending", bus.cfg_pending, 0);
      reset = 1'b0;
      measure(12);
      $display("seq F: ticks after reset at %0d %0d %0d", tick_at(0), tick_at(1), tick_at(2));
      check("f_first_tick", tick_at(0), 0);
      check("f_period_1", tick_at(1) - tick_at(0), RESET_BAUD + 1);
      check("f_period_2", tick_at(2) - tick_at(1), RESET_BAUD + 1);

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 499) == 0);
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
               int'($urandom_range(0, 4)), int'($urandom_range(0, 15)));
         step(1);
         if (c % 250 == 249)
            $display("random cycles %0d..%0d: tc=%0d pend=%0b", c - 249, c, bus.tick_cnt, bus.cfg_pending);
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
